tea_block_packer: RTL
=====================

// Module: tea_block_packer
// PURPOSE
//   Upstream stage of tea_accelerator: packs an 8-bit AXI-Stream byte message into 64-bit TEA
//   blocks on the accelerator's i_axis_*_s port. Applies PKCS#7 padding on the final block when
//   PAD_EN=1, otherwise zero-fills it. Flags the final block with o_axis_last_m.
// PARAMETERS
//   PAD_EN   1  1: PKCS#7 padding, extra 0x08 x8 block on 8-byte-aligned messages; 0: zero-fill, no extra block
//   BYTE_BE  1  1: first byte of block -> data[63:56]; 0: first byte -> data[7:0]
// PORTS
//   i_clk           in   1   clock, all logic on rising edge
//   i_rst           in   1   synchronous, active-high reset
//   i_axis_valid_s  in   1   byte valid
//   o_axis_ready_s  out  1   byte ready
//   i_axis_data_s   in   8   message byte
//   i_axis_last_s   in   1   final byte of message
//   o_axis_valid_m  out  1   block valid (to tea_accelerator i_axis_valid_s)
//   i_axis_ready_m  in   1   block ready (from tea_accelerator o_axis_ready_s)
//   o_axis_data_m   out  64  packed block
//   o_axis_last_m   out  1   final block of message
// BEHAVIOUR
//   - One clock, synchronous active-high reset. Reset: state=FILL, byte_cnt=0, pad_pend=0,
//     o_axis_valid_m=0, o_axis_last_m=0, o_axis_data_m=0, o_axis_ready_s=0 while i_rst=1.
//   - Handshake: transfer when valid && ready on a rising edge. o_axis_valid_m, data and last are
//     registered and held stable until accepted. Valid never drops without a handshake.
//   - o_axis_ready_s = (state==FILL) && !i_rst. Input stalls during EMIT; no overlap.
//   - FILL: each accepted byte is written to lane byte_cnt (0..7, placed per BYTE_BE); byte_cnt++.
//       * byte_cnt==7, last=0       -> EMIT, last_m=0, byte_cnt=0.
//       * byte_cnt==7, last=1       -> EMIT. PAD_EN=1: last_m=0, pad_pend=1. PAD_EN=0: last_m=1.
//       * byte_cnt<7,  last=1       -> lanes byte_cnt+1..7 filled with N=7-byte_cnt (PAD_EN=1)
//                                      or 0x00 (PAD_EN=0); EMIT, last_m=1, byte_cnt=0.
//       * no accepted byte          -> hold. Partial lanes are retained indefinitely.
//   - EMIT: o_axis_valid_m=1. On block handshake:
//       * pad_pend=1 -> data=64'h0808_0808_0808_0808, last_m=1, pad_pend=0, stay EMIT.
//       * else       -> valid_m=0, FILL.
//   - Latency: block valid on the cycle after the handshake of its 8th (or last) byte.
//     Throughput: 8 bytes + >=1 emit cycle per block.
//   - Lane-fill values: byte_cnt index is 3 bits; no wrap beyond 7. Pad value N is in 1..7 on a
//     partial block and 8 on the pad block.
//   - Output-side backpressure: i_axis_ready_m held low keeps EMIT, data and last frozen.
//     Input bytes are not accepted.
//   - Empty message: not representable, since last always rides on a real byte.
//   - Reset mid-operation (any state): partial block, pad_pend and pending output are discarded.
//     The next byte after reset starts at lane 0.
// TESTING
//   1 8 bytes 00..07, last on 07, PAD_EN=1, BE -> block 0x0001020304050607 last=0,
//     then 0x0808080808080808 last=1.
//   2 3 bytes AA,BB,CC last on CC, PAD_EN=1 -> single block 0xAABBCC0505050505 last=1.
//   3 Same as 2 with PAD_EN=0 -> 0xAABBCC0000000000 last=1; aligned 8-byte msg -> one block last=1.
//   4 Hold i_axis_ready_m=0 for 20 cycles after block valid -> valid/data/last stable,
//     o_axis_ready_s=0 throughout; release -> one handshake, back to FILL.
//   5 Assert i_rst after 5 bytes, then send 8 new bytes 10..17 -> first block 0x1011121314151617;
//     no stale lanes.
//   6 Random valid_s/ready_m gaps, 1000 random-length messages -> output byte stream minus padding
//     equals input. Exactly one last_m per message.
//     Pad bytes are valid PKCS#7.

Source files
------------

// File: rtl/tea_block_packer.sv
// rtl/tea_block_packer.sv - packs an 8-bit byte stream into 64-bit TEA blocks with PKCS#7 or zero fill
module tea_block_packer #(
  parameter bit PAD_EN  = 1'b1,
  parameter bit BYTE_BE = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_axis_valid_s,
  output logic        o_axis_ready_s,
  input  logic [7:0]  i_axis_data_s,
  input  logic        i_axis_last_s,
  output logic        o_axis_valid_m,
  input  logic        i_axis_ready_m,
  output logic [63:0] o_axis_data_m,
  output logic        o_axis_last_m
);

  typedef enum logic {FILL, EMIT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic        pad_pend_q, pad_pend_d;
  logic [63:0] buf_q, buf_d;
  logic [63:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [63:0] merged;
  logic [63:0] padded;
  logic [7:0]  pad_val;

  function automatic logic [5:0] lane_base(input logic [2:0] idx);
    return {(BYTE_BE ? (3'd7 - idx) : idx), 3'b000};
  endfunction

  assign o_axis_ready_s = (state_q == FILL) && !i_rst;
  assign o_axis_valid_m = valid_q;
  assign o_axis_data_m  = data_q;
  assign o_axis_last_m  = last_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pad_pend_d = pad_pend_q;
    buf_d      = buf_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    pad_val    = PAD_EN ? {5'd0, 3'd7 - byte_cnt_q} : 8'h00;

    merged = buf_q;
    merged[lane_base(byte_cnt_q) +: 8] = i_axis_data_s;
    // Lanes above the current byte are still zero, so only PKCS#7 needs explicit filling.
    padded = merged;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) > byte_cnt_q) padded[lane_base(3'(i)) +: 8] = pad_val;
    end

    case (state_q)
      FILL: begin
        if (i_axis_valid_s) begin
          if (byte_cnt_q == 3'd7 || i_axis_last_s) begin
            state_d    = EMIT;
            valid_d    = 1'b1;
            byte_cnt_d = 3'd0;
            buf_d      = 64'd0;
            data_d     = i_axis_last_s ? padded : merged;
            // An aligned final block under PKCS#7 is followed by a whole block of 0x08.
            pad_pend_d = PAD_EN && i_axis_last_s && (byte_cnt_q == 3'd7);
            last_d     = i_axis_last_s && !(PAD_EN && (byte_cnt_q == 3'd7));
          end else begin
            buf_d      = merged;
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      EMIT: begin
        if (i_axis_ready_m) begin
          if (pad_pend_q) begin
            data_d     = 64'h0808_0808_0808_0808;
            last_d     = 1'b1;
            pad_pend_d = 1'b0;
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= FILL;
      byte_cnt_q <= 3'd0;
      pad_pend_q <= 1'b0;
      buf_q      <= 64'd0;
      data_q     <= 64'd0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pad_pend_q <= pad_pend_d;
      buf_q      <= buf_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

endmodule
